// File: rtl/rca_chunk_seq_pkg.sv
// Shared definitions for the chunked ripple-carry adder sequencer.
// Holds the controller state encoding, the default chunk geometry and
// the signed-overflow helper used on the final chunk.
package rca_chunk_seq_pkg;

  localparam int DEF_BITS   = 8;
  localparam int DEF_CHUNKS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's-complement overflow: operands share a sign and the result sign differs.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
    logic res_s;
    res_s = (a_msb == b_msb) && (s_msb != a_msb);
    return res_s;
  endfunction

endpackage

// File: rtl/rca_chunk_seq_rca.sv
// Combinational BITS-wide ripple-carry adder, the one shared arithmetic
// slice reused for every chunk of the wide operation.
// Ports: a0, a1 - addends; ci - carry in; sum - BITS-bit sum; co - carry out.
module rca
  import rca_chunk_seq_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input  logic [BITS-1:0] a0,
  input  logic [BITS-1:0] a1,
  input  logic            ci,
  output logic [BITS-1:0] sum,
  output logic            co
);

  logic [BITS:0] c_s;

  assign c_s[0] = ci;

  for (genvar i = 0; i < BITS; i++) begin : g_fa
    assign sum[i]   = a0[i] ^ a1[i] ^ c_s[i];
    assign c_s[i+1] = (a0[i] & a1[i]) | (c_s[i] & (a0[i] ^ a1[i]));
  end

  assign co = c_s[BITS];

endmodule

// File: rtl/rca_chunk_seq.sv
// Multi-cycle wide adder: adds two BITS*CHUNKS-bit operands one BITS-bit chunk
// per cycle (LSB chunk first) through a single shared rca slice, carrying
// between chunks in a register.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   start         - request, accepted only when not busy
//   a, b, ci      - operands and carry-in, captured on the accepting edge
//   busy          - high while chunks are being processed
//   done          - one-cycle pulse when sum/co/ovf are fresh
//   sum, co, ovf  - result, carry out of the top bit, signed overflow; held
//                   until the next done
module rca_chunk_seq
  import rca_chunk_seq_pkg::*;
#(
  parameter int BITS   = DEF_BITS,
  parameter int CHUNKS = DEF_CHUNKS,
  parameter int CW     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BITS*CHUNKS-1:0]   a,
  input  logic [BITS*CHUNKS-1:0]   b,
  input  logic                     ci,
  output logic                     busy,
  output logic                     done,
  output logic [BITS*CHUNKS-1:0]   sum,
  output logic                     co,
  output logic                     ovf
);

  localparam int W = BITS * CHUNKS;

  state_t          state_r;
  logic [W-1:0]    a_sh_r;
  logic [W-1:0]    b_sh_r;
  logic [W-1:0]    res_sh_r;
  logic            cy_r;
  logic [CW-1:0]   cnt_r;
  logic [W-1:0]    sum_r;
  logic            co_r;
  logic            ovf_r;

  logic [BITS-1:0] rca_sum_s;
  logic            rca_co_s;

  rca #(.BITS(BITS)) u_rca (
    .co  (rca_co_s),
    .sum (rca_sum_s),
    .a0  (a_sh_r[BITS-1:0]),
    .a1  (b_sh_r[BITS-1:0]),
    .ci  (cy_r)
  );

  // Controller FSM, operand/result shifters, chunk counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      a_sh_r   <= {W{1'b0}};
      b_sh_r   <= {W{1'b0}};
      res_sh_r <= {W{1'b0}};
      cy_r     <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      sum_r    <= {W{1'b0}};
      co_r     <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            cy_r    <= ci;
            cnt_r   <= {CW{1'b0}};
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh_r   <= a_sh_r >> BITS;
          b_sh_r   <= b_sh_r >> BITS;
          res_sh_r <= {rca_sum_s, res_sh_r[W-1:BITS]};
          cy_r     <= rca_co_s;
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == CW'(CHUNKS - 1)) begin
            // Top chunk is on the slice now, so its MSBs are the operand sign bits.
            sum_r   <= {rca_sum_s, res_sh_r[W-1:BITS]};
            co_r    <= rca_co_s;
            ovf_r   <= ovf_calc(a_sh_r[BITS-1], b_sh_r[BITS-1], rca_sum_s[BITS-1]);
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (start) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            cy_r    <= ci;
            cnt_r   <= {CW{1'b0}};
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_r == ST_RUN);
  assign done = (state_r == ST_DONE);
  assign sum  = sum_r;
  assign co   = co_r;
  assign ovf  = ovf_r;

endmodule
